// File: rtl/udma_pkg.sv
// Shared uDMA helpers.
// Provides a clog2-style log2 used to size counters and pointers from depth parameters.
package udma_pkg;

  // Smallest r with 2**r >= n; log2(1) == 0.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/io_rx_os_counter.sv
// Outstanding-write counter for the RX FIFO.
// Ports: clk_i/rstn_i (sync active-low reset), inc_i (grant), dec_i (response),
//        count_o (outstanding writes), below_max_o (another grant allowed),
//        underflow_o (response seen with nothing outstanding and no grant this cycle).
module io_rx_os_counter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_WIDTH       = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 below_max_o,
  output logic                 underflow_o
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  // Simultaneous inc/dec cancel, which also covers a response arriving with its own grant.
  always_comb begin
    count_d     = count_q;
    underflow_o = 1'b0;
    case ({inc_i, dec_i})
      2'b10: count_d = count_q + CNT_WIDTH'(1);
      2'b01: begin
        if (count_q == '0) underflow_o = 1'b1;
        else               count_d     = count_q - CNT_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o     = count_q;
  assign below_max_o = (count_q < CNT_WIDTH'(MAX_OUTSTANDING));

endmodule

// File: rtl/io_rx_fifo.sv
// RX-direction uDMA FIFO: buffers peripheral words and drains them to L2 as
// req/gnt write requests while tracking outstanding write responses.
// Ports: clk_i, rstn_i (sync active-low), clr_i (flush + clear err),
//        valid_i/data_i/ready_o (peripheral push side),
//        req_o/gnt_i/data_o (L2 write side), rvalid_i (write response),
//        elements_o, outstanding_o, busy_o, err_o (status).
module io_rx_fifo
  import udma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned BUFFER_DEPTH        = 4,
  parameter int unsigned LOG_BUFFER_DEPTH    = log2(BUFFER_DEPTH),
  parameter int unsigned MAX_OUTSTANDING     = 2,
  parameter int unsigned LOG_MAX_OUTSTANDING = log2(MAX_OUTSTANDING)
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           clr_i,
  input  logic                           valid_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  output logic                           ready_o,
  output logic                           req_o,
  input  logic                           gnt_i,
  output logic [DATA_WIDTH-1:0]          data_o,
  input  logic                           rvalid_i,
  output logic [LOG_BUFFER_DEPTH:0]      elements_o,
  output logic [LOG_MAX_OUTSTANDING:0]   outstanding_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int unsigned PTR_W  = LOG_BUFFER_DEPTH;
  localparam int unsigned ELEM_W = LOG_BUFFER_DEPTH + 1;
  localparam int unsigned OS_W   = LOG_MAX_OUTSTANDING + 1;

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ELEM_W-1:0]     elements_q, elements_d;
  logic                  err_q, err_d;
  logic                  push, pop;
  logic                  os_below_max, os_underflow;
  logic [OS_W-1:0]       os_count;

  // Handshake gating; ready_o deliberately ignores gnt_i so a full FIFO frees a slot only next cycle.
  assign ready_o = (elements_q < ELEM_W'(BUFFER_DEPTH)) & rstn_i;
  assign req_o   = (elements_q != '0) & os_below_max & rstn_i & ~clr_i;
  assign push    = valid_i & ready_o & ~clr_i;
  assign pop     = req_o & gnt_i;

  // Pointer and occupancy next-state; clear flushes everything except outstanding writes.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    elements_d = elements_q;
    if (clr_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      elements_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   elements_d = elements_q + ELEM_W'(1);
        2'b01:   elements_d = elements_q - ELEM_W'(1);
        default: ;
      endcase
    end
  end

  // Sticky error; clear has priority over a new underflow.
  always_comb begin
    err_d = err_q;
    if (clr_i)             err_d = 1'b0;
    else if (os_underflow) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      elements_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      elements_q <= elements_d;
      err_q      <= err_d;
    end
  end

  // Word storage
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(BUFFER_DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  io_rx_os_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_WIDTH       (OS_W)
  ) u_os_counter (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .inc_i       (pop),
    .dec_i       (rvalid_i),
    .count_o     (os_count),
    .below_max_o (os_below_max),
    .underflow_o (os_underflow)
  );

  assign data_o        = mem_q[rd_ptr_q];
  assign elements_o    = elements_q;
  assign outstanding_o = os_count;
  assign busy_o        = (elements_q != '0) | (os_count != '0);
  assign err_o         = err_q;

endmodule

// File: tb/tb_io_rx_fifo.sv
module tb_io_rx_fifo;

  logic        clk_i;
  logic        rstn_i;
  logic        clr_i;
  logic        valid_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        req_o;
  logic        gnt_i;
  logic [31:0] data_o;
  logic        rvalid_i;
  logic [2:0]  elements_o;
  logic [1:0]  outstanding_o;
  logic        busy_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  io_rx_fifo #(
    .DATA_WIDTH      (32),
    .BUFFER_DEPTH    (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .clr_i         (clr_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .ready_o       (ready_o),
    .req_o         (req_o),
    .gnt_i         (gnt_i),
    .data_o        (data_o),
    .rvalid_i      (rvalid_i),
    .elements_o    (elements_o),
    .outstanding_o (outstanding_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; clr_i = 1'b0; valid_i = 1'b0; data_i = '0; gnt_i = 1'b0; rvalid_i = 1'b0;
    cyc(); cyc();
    rstn_i = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; clr_i = 1'b0; valid_i = 1'b1; data_i = 32'h55; gnt_i = 1'b1; rvalid_i = 1'b0;
    repeat (3) cyc();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", req_o); end
    checks++; if (elements_o !== 3'd0) begin errors++; $display("FAIL reset_elements got=%0d exp=0", elements_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
    valid_i = 1'b0; gnt_i = 1'b0; rstn_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", ready_o); end
    sb.delete();
  endtask

  // Push 0xA0..0xA3 with no grants; leaves the FIFO full for the next test.
  task automatic test_fill();
    gnt_i = 1'b0; rvalid_i = 1'b0; valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 32'hA0 + 32'(i);
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready i=%0d got=%b exp=1", i, ready_o); end
      checks++; if (req_o !== (i != 0)) begin errors++; $display("FAIL fill_req i=%0d got=%b exp=%b", i, req_o, (i != 0)); end
      sb.push_back(data_i);
      cyc();
      checks++; if (elements_o !== 3'(i + 1)) begin errors++; $display("FAIL fill_elements i=%0d got=%0d exp=%0d", i, elements_o, i + 1); end
    end
    valid_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", ready_o); end
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL fill_req_high got=%b exp=1", req_o); end
    checks++; if (data_o !== 32'hA0) begin errors++; $display("FAIL fill_head got=%h exp=a0", data_o); end
  endtask

  task automatic test_os_limit();
    logic [31:0] exp;
    gnt_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL oslim_req k=%0d got=%b exp=1", k, req_o); end
      exp = sb.pop_front();
      checks++; if (data_o !== exp) begin errors++; $display("FAIL oslim_data k=%0d got=%h exp=%h", k, data_o, exp); end
      cyc();
    end
    #1;
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL oslim_req_blocked got=%b exp=0", req_o); end
    checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL oslim_outstanding got=%0d exp=2", outstanding_o); end
    checks++; if (elements_o !== 3'd2) begin errors++; $display("FAIL oslim_elements got=%0d exp=2", elements_o); end
    cyc();
    checks++; if (elements_o !== 3'd2) begin errors++; $display("FAIL oslim_gnt_ignored got=%0d exp=2", elements_o); end
    gnt_i = 1'b0; rvalid_i = 1'b1;
    cyc();
    rvalid_i = 1'b0;
    #1;
    checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL oslim_after_rvalid got=%0d exp=1", outstanding_o); end
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL oslim_req_resumed got=%b exp=1", req_o); end
    gnt_i = 1'b1;
    #1;
    exp = sb.pop_front();
    checks++; if (data_o !== exp || data_o !== 32'hA2) begin errors++; $display("FAIL oslim_third_grant got=%h exp=%h", data_o, exp); end
    cyc();
    gnt_i = 1'b0;
    #1;
    checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL oslim_final_outstanding got=%0d exp=2", outstanding_o); end
    checks++; if (elements_o !== 3'd1) begin errors++; $display("FAIL oslim_final_elements got=%0d exp=1", elements_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL oslim_busy got=%b exp=1", busy_o); end
  endtask

  // Full FIFO with push and grant every cycle: 8 words through a 4-deep FIFO in order.
  task automatic test_full_simul();
    int elems;
    int idx;
    bit exp_ready, exp_req;
    logic [31:0] exp;
    do_reset();
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 32'hA0 + 32'(i);
      sb.push_back(data_i);
      cyc();
    end
    elems = 4; idx = 4;
    for (int c = 0; c < 40 && (sb.size() != 0 || idx < 8); c++) begin
      valid_i = (idx < 8); data_i = 32'hA0 + 32'(idx); gnt_i = 1'b1; rvalid_i = (elems != 0);
      #1;
      exp_ready = (elems < 4); exp_req = (elems != 0);
      checks++; if (ready_o !== exp_ready) begin errors++; $display("FAIL full_ready c=%0d got=%b exp=%b", c, ready_o, exp_ready); end
      checks++; if (req_o !== exp_req) begin errors++; $display("FAIL full_req c=%0d got=%b exp=%b", c, req_o, exp_req); end
      if (exp_req) begin
        exp = sb.pop_front();
        checks++; if (data_o !== exp) begin errors++; $display("FAIL full_order c=%0d got=%h exp=%h", c, data_o, exp); end
      end
      if (valid_i && exp_ready) begin sb.push_back(data_i); idx++; end
      elems = elems + int'(valid_i && exp_ready) - int'(exp_req);
      cyc();
      checks++; if (elements_o !== 3'(elems)) begin errors++; $display("FAIL full_elements c=%0d got=%0d exp=%0d", c, elements_o, elems); end
    end
    valid_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0;
    #1;
    checks++; if (sb.size() != 0 || idx != 8) begin errors++; $display("FAIL full_timeout left=%0d idx=%0d exp=0,8", sb.size(), idx); end
    checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL full_outstanding got=%0d exp=0", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL full_err got=%b exp=0", err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL full_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_err_clear();
    logic [31:0] exp;
    do_reset();
    rvalid_i = 1'b1;
    cyc();
    rvalid_i = 1'b0;
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_stray got=%b exp=1", err_o); end
    checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL err_no_underflow got=%0d exp=0", outstanding_o); end
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 32'hB0 + 32'(i);
      sb.push_back(data_i);
      cyc();
    end
    valid_i = 1'b0; gnt_i = 1'b1;
    #1;
    exp = sb.pop_front();
    checks++; if (data_o !== exp) begin errors++; $display("FAIL err_grant_data got=%h exp=%h", data_o, exp); end
    cyc();
    gnt_i = 1'b1; clr_i = 1'b1; valid_i = 1'b1; data_i = 32'hEE;
    #1;
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL clr_req_forced got=%b exp=0", req_o); end
    cyc();
    clr_i = 1'b0; valid_i = 1'b0; gnt_i = 1'b0;
    sb.delete();
    #1;
    checks++; if (elements_o !== 3'd0) begin errors++; $display("FAIL clr_elements got=%0d exp=0", elements_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL clr_err got=%b exp=0", err_o); end
    checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL clr_outstanding got=%0d exp=1", outstanding_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL clr_busy got=%b exp=1", busy_o); end
    rvalid_i = 1'b1;
    cyc();
    rvalid_i = 1'b0;
    #1;
    checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL clr_resp_outstanding got=%0d exp=0", outstanding_o); end
    checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL clr_resp_idle busy=%b err=%b exp=0,0", busy_o, err_o); end
    rvalid_i = 1'b1; clr_i = 1'b1;
    cyc();
    rvalid_i = 1'b0; clr_i = 1'b0;
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL clr_wins got=%b exp=0", err_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid_i = 1'b1; data_i = 32'hC0;
    cyc();
    data_i = 32'hC1;
    cyc();
    valid_i = 1'b0; gnt_i = 1'b1;
    cyc();
    gnt_i = 1'b0; rstn_i = 1'b0;
    cyc();
    rstn_i = 1'b1;
    #1;
    checks++; if (elements_o !== 3'd0 || outstanding_o !== 2'd0) begin errors++; $display("FAIL rstmid_state got=%0d/%0d exp=0/0", elements_o, outstanding_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
    rvalid_i = 1'b1;
    cyc();
    rvalid_i = 1'b0;
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL rstmid_stray_err got=%b exp=1", err_o); end
  endtask

  task automatic test_back_to_back();
    int elems, os;
    bit exp_ready, exp_req, do_push, do_pop, rv;
    logic [31:0] exp;
    do_reset();
    elems = 0; os = 0;
    for (int c = 0; c < 10000; c++) begin
      valid_i = 1'($urandom_range(0, 1));
      data_i = $urandom;
      gnt_i = ($urandom_range(0, 3) != 0);
      rv = (os > 0) && ($urandom_range(0, 2) == 0);
      rvalid_i = rv;
      #1;
      exp_ready = (elems < 4);
      exp_req = (elems != 0) && (os < 2);
      do_push = valid_i && exp_ready;
      do_pop = exp_req && gnt_i;
      checks++; if (ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, ready_o, exp_ready); end
      checks++; if (req_o !== exp_req) begin errors++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, req_o, exp_req); end
      checks++; if (busy_o !== ((elems != 0) || (os != 0))) begin errors++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy_o, ((elems != 0) || (os != 0))); end
      if (do_pop) begin
        exp = sb.pop_front();
        checks++; if (data_o !== exp) begin errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, data_o, exp); end
      end
      if (do_push) sb.push_back(data_i);
      elems = elems + int'(do_push) - int'(do_pop);
      os = os + int'(do_pop) - int'(rv);
      cyc();
      checks++; if (elements_o !== 3'(elems)) begin errors++; $display("FAIL rnd_elements c=%0d got=%0d exp=%0d", c, elements_o, elems); end
      checks++; if (outstanding_o !== 2'(os)) begin errors++; $display("FAIL rnd_outstanding c=%0d got=%0d exp=%0d", c, outstanding_o, os); end
    end
    valid_i = 1'b0;
    for (int c = 0; c < 100 && (elems != 0 || os != 0); c++) begin
      gnt_i = 1'b1;
      rv = (os > 0);
      rvalid_i = rv;
      #1;
      do_pop = (elems != 0) && (os < 2);
      if (do_pop) begin
        exp = sb.pop_front();
        checks++; if (data_o !== exp) begin errors++; $display("FAIL drain_data c=%0d got=%h exp=%h", c, data_o, exp); end
      end
      elems = elems - int'(do_pop);
      os = os + int'(do_pop) - int'(rv);
      cyc();
    end
    gnt_i = 1'b0; rvalid_i = 1'b0;
    #1;
    checks++; if (elems != 0 || os != 0 || sb.size() != 0) begin errors++; $display("FAIL drain_timeout elems=%0d os=%0d sb=%0d exp=0", elems, os, sb.size()); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL drain_busy got=%b exp=0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL drain_err got=%b exp=0", err_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_os_limit();
    test_full_simul();
    test_err_clear();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
